// File: rtl/bist_pattern_engine.sv
// bist_pattern_engine
//   Self-test engine for a small gate-level circuit. An 8-bit Fibonacci LFSR
//   supplies two pattern bits per cycle and an 8-bit MISR compacts the two
//   response bits. The engine owns the circuit's reset for the length of a run.
//
//   Sequence: IDLE -> INIT (1 cycle) -> RUN (N_PATTERNS cycles)
//             -> FLUSH (1 cycle) -> DONE
//
//   Optional build macro: BIST_GOLDEN_COMPARE_EN
//     defined   : pass is a registered flag, signature == GOLDEN at DONE entry
//     undefined : pass is tied low and GOLDEN has no effect
module bist_pattern_engine #(
    parameter int unsigned N_PATTERNS = 64,
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [7:0]  GOLDEN     = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       dut_reset,
    output logic       dut_i1,
    output logic       dut_i2,
    input  logic       dut_o1,
    input  logic       dut_o2,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature,
    output logic       pass
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // An all-zero LFSR would never leave zero, so a zero seed is replaced.
    localparam logic [7:0]  SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] LAST_CNT = 16'(N_PATTERNS - 1);

    // Shared shift-with-feedback for both LFSR and MISR (taps 7,5,4,3).
    function automatic logic [7:0] shift8(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  lfsr;
    logic [7:0]  misr;
    logic [7:0]  misr_nxt;
    logic [15:0] cnt;
    logic        drive_pat;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start only matters in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = RUN;
            RUN:     if (cnt == LAST_CNT) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    if (start) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
    end

    assign misr_nxt = shift8(misr) ^ {6'b0, dut_o2, dut_o1};

    // Pattern generator, signature register and pattern counter.
    // INIT loads the seed and takes one step, so the first RUN pattern is one
    // step past the seed and every RUN cycle shows a fresh LFSR value.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED_FIX;
            misr <= 8'h00;
            cnt  <= 16'd0;
        end else begin
            unique case (state)
                INIT: begin
                    lfsr <= shift8(SEED_FIX);
                    misr <= 8'h00;
                    cnt  <= 16'd0;
                end
                RUN: begin
                    lfsr <= shift8(lfsr);
                    misr <= misr_nxt;
                    cnt  <= cnt + 16'd1;
                end
                FLUSH: begin
                    // One extra capture observes the last registered response.
                    misr <= misr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign drive_pat = (state == RUN) || (state == FLUSH);
    assign dut_i1    = drive_pat & lfsr[0];
    assign dut_i2    = drive_pat & lfsr[1];
    assign dut_reset = reset | (state == INIT);
    assign busy      = (state == INIT) || (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);
    assign signature = misr;

`ifdef BIST_GOLDEN_COMPARE_EN
    // Verdict latched on the FLUSH->DONE edge from the final signature value.
    always_ff @(posedge clock) begin
        if (reset)               pass <= 1'b0;
        else if (state == INIT)  pass <= 1'b0;
        else if (state == FLUSH) pass <= (misr_nxt == GOLDEN);
    end
`else
    // No comparator in this build; GOLDEN is folded away to a constant 0.
    assign pass = 1'b0 & (^GOLDEN);
`endif

endmodule

// File: tb/tb_bist_pattern_engine.sv
// tb_bist_pattern_engine
//   Three engines, each beside a tiny register-plus-gates netlist:
//     u0: N=64, SEED=01, GOLDEN=model signature (stuck-at-0 injectable on o1)
//     u1: N=64, SEED=01, GOLDEN=model signature ^ 1 (shares start with u0)
//     u2: N=4,  SEED=00
//   Expected patterns and signatures come from a sequential model of the
//   whole loop written as a plain per-cycle loop over the spec rules.
module tb_bist_pattern_engine;

`ifdef BIST_GOLDEN_COMPARE_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    function automatic logic [7:0] step8(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Pattern shown in RUN/FLUSH cycle j (1-based) as {i2,i1}.
    function automatic logic [1:0] model_pat(input logic [7:0] seed, input int j);
        logic [7:0] l;
        l = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < j; k++) l = step8(l);
        return l[1:0];
    endfunction

    // Netlist: r <= i1^i2 (cleared by dut_reset); o1 = r, o2 = r^i1.
    // r is 0 in the first RUN cycle because INIT holds the netlist in reset.
    function automatic logic [7:0] model_sig(input logic [7:0] seed, input int n, input bit stuck);
        logic [7:0] l, m;
        logic r, i1, i2, o1, o2;
        l = (seed == 8'h00) ? 8'h01 : seed;
        m = 8'h00;
        r = 1'b0;
        for (int j = 1; j <= n + 1; j++) begin
            l  = step8(l);
            i1 = l[0];
            i2 = l[1];
            o1 = stuck ? 1'b0 : r;
            o2 = r ^ i1;
            m  = step8(m) ^ {6'b0, o2, o1};
            r  = i1 ^ i2;
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(8'h01, 64, 1'b0);

    logic       clock = 1'b0;
    logic       reset;
    logic       start0, start2;
    logic       stuck;
    logic [2:0] dres, di1, di2, do1, do2, nr, busy, done, pass;
    logic [7:0] sig [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Circuit under test models, one per engine.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) nr[i] <= dres[i] ? 1'b0 : (di1[i] ^ di2[i]);
    end
    assign do1 = {nr[2:1], stuck ? 1'b0 : nr[0]};
    assign do2 = nr ^ di1;

    bist_pattern_engine #(.N_PATTERNS(64), .SEED(8'h01), .GOLDEN(GOLD)) u0 (
        .clock(clock), .reset(reset), .start(start0), .dut_reset(dres[0]),
        .dut_i1(di1[0]), .dut_i2(di2[0]), .dut_o1(do1[0]), .dut_o2(do2[0]),
        .busy(busy[0]), .done(done[0]), .signature(sig[0]), .pass(pass[0]));

    bist_pattern_engine #(.N_PATTERNS(64), .SEED(8'h01), .GOLDEN(GOLD ^ 8'h01)) u1 (
        .clock(clock), .reset(reset), .start(start0), .dut_reset(dres[1]),
        .dut_i1(di1[1]), .dut_i2(di2[1]), .dut_o1(do1[1]), .dut_o2(do2[1]),
        .busy(busy[1]), .done(done[1]), .signature(sig[1]), .pass(pass[1]));

    bist_pattern_engine #(.N_PATTERNS(4), .SEED(8'h00), .GOLDEN(8'h00)) u2 (
        .clock(clock), .reset(reset), .start(start2), .dut_reset(dres[2]),
        .dut_i1(di1[2]), .dut_i2(di2[2]), .dut_o1(do1[2]), .dut_o2(do2[2]),
        .busy(busy[2]), .done(done[2]), .signature(sig[2]), .pass(pass[2]));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int idx, input logic v);
        if (idx == 2) start2 = v;
        else          start0 = v;
    endtask

    // Full run on engine idx; junk=1 pulses start at a random RUN cycle.
    task automatic run(input int idx, input int n, input logic [7:0] seed, input bit junk,
                       input bit stk, input logic [7:0] gold);
        logic [7:0] rcnt;
        logic [7:0] esig, esig1;
        int junk_at;
        esig    = model_sig(seed, n, stk);
        esig1   = model_sig(seed, n, 1'b0);
        junk_at = junk ? int'($urandom_range(1, n)) : 0;
        @(negedge clock) set_start(idx, 1'b1);
        @(negedge clock) set_start(idx, 1'b0);
        // INIT cycle
        chk("init_busy", 8'(busy[idx]), 8'd1);
        chk("init_dres", 8'(dres[idx]), 8'd1);
        chk("init_pat",  {6'b0, di2[idx], di1[idx]}, 8'h00);
        rcnt = 8'd1;
        for (int j = 1; j <= n + 1; j++) begin
            @(negedge clock);
            set_start(idx, (j == junk_at) ? 1'b1 : 1'b0);
            chk("pat", {6'b0, di2[idx], di1[idx]}, {6'b0, model_pat(seed, j)});
            if (j == 1) chk("run1_misr_clr", sig[idx], 8'h00);
            if (j == 1 && seed == 8'h00) chk("zs_first", {6'b0, di2[idx], di1[idx]}, 8'h02);
            if (j == n + 1) chk("flush_busy", {6'b0, busy[idx], done[idx]}, 8'h02);
            rcnt = rcnt + 8'(dres[idx]);
        end
        @(negedge clock);
        set_start(idx, 1'b0);
        chk("dres_cycles", rcnt, 8'd1);
        chk("done", {6'b0, busy[idx], done[idx]}, 8'h01);
        chk("sig", sig[idx], esig);
        chk("pass", 8'(pass[idx]), 8'(CMP_EN && (esig == gold)));
        if (idx == 0) begin
            chk("sig_u1",  sig[1], esig1);
            chk("pass_u1", 8'(pass[1]), 8'(CMP_EN && (esig1 == (GOLD ^ 8'h01))));
        end
        repeat (2) @(negedge clock);
        chk("done_hold", {5'b0, done[idx], busy[idx], dres[idx]}, 8'h04);
        chk("sig_hold",  sig[idx], esig);
    endtask

    // Reset partway into RUN; start is raised with reset and must lose.
    task automatic mid_reset(input int rc);
        @(negedge clock) start0 = 1'b1;
        @(negedge clock) start0 = 1'b0;
        repeat (rc) @(negedge clock);
        reset  = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        chk("mr_busy", {6'b0, busy[0], done[0]}, 8'h00);
        chk("mr_sig",  sig[0], 8'h00);
        chk("mr_dres", 8'(dres[0]), 8'd1);
        chk("mr_pat",  {6'b0, di2[0], di1[0]}, 8'h00);
        chk("mr_pass", 8'(pass[0]), 8'd0);
        reset  = 1'b0;
        start0 = 1'b0;
        @(negedge clock);
        chk("mr_idle", {5'b0, busy[0], done[0], dres[0]}, 8'h00);
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        stuck  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_flags", {5'b0, busy[0], done[0], dres[0]}, 8'h01);
        chk("rst_pat",   {6'b0, di2[0], di1[0]}, 8'h00);
        chk("rst_sig",   sig[0], 8'h00);
        chk("rst_pass",  8'(pass[0]), 8'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("idle_flags", {5'b0, busy[0], done[0], dres[0]}, 8'h00);
        chk("idle_pat",   {6'b0, di2[0], di1[0]}, 8'h00);
        chk("idle_sig",   sig[0], 8'h00);

        run(2, 4, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat ($urandom_range(0, 5)) @(negedge clock);
        run(0, 64, 8'h01, 1'b1, 1'b0, GOLD);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        run(0, 64, 8'h01, 1'b0, 1'b0, GOLD);
        mid_reset(10);
        run(0, 64, 8'h01, 1'b1, 1'b0, GOLD);
        mid_reset(int'($urandom_range(1, 62)));
        stuck = 1'b1;
        run(0, 64, 8'h01, 1'b0, 1'b1, GOLD);
        stuck = 1'b0;
        run(0, 64, 8'h01, 1'b1, 1'b0, GOLD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
